// File: rtl/iz_param_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iz_param_pkg : shared constants, frame length and FSM states             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package iz_param_pkg;

  localparam int unsigned PARAM_W = 32;
  localparam int unsigned A_MSB   = 31;
  localparam int unsigned B_MSB   = 23;
  localparam int unsigned C_MSB   = 15;
  localparam int unsigned D_MSB   = 7;

  // Parity-enabled builds append one even-parity bit after d[0].
  function automatic int unsigned frame_bits();
`ifdef IZ_PARAM_PARITY_EN
    return PARAM_W + 1;
`else
    return PARAM_W;
`endif
  endfunction

  localparam int unsigned FRAME_BITS = frame_bits();

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/iz_param_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iz_param_if : parameter-word handshake plus serial load-port signals     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface iz_param_if;
  import iz_param_pkg::*;

  logic [PARAM_W-1:0] param_word;
  logic               param_valid;
  logic               param_ready;
  logic               abort;
  logic               load_mode;
  logic               serial_data;
  logic               busy;
  logic               done;

  modport master (
    output param_word, param_valid, abort,
    input  param_ready, load_mode, serial_data, busy, done
  );

  modport slave (
    input  param_word, param_valid, abort,
    output param_ready, load_mode, serial_data, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/iz_param_serializer_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iz_bit_timer : one-cycle bit_end strobe every CLKS_PER_BIT enabled cycles|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module iz_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] tick_q;

  assign bit_end_o = en_i && (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else if (clr_i) begin
      tick_q <= '0;
    end else if (en_i) begin
      tick_q <= (tick_q == TICK_LAST) ? 8'd0 : tick_q + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iz_param_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iz_param_serializer : frames a 32-bit {a,b,c,d} word onto load_mode /    |
// | serial_data, MSB first. Define IZ_PARAM_PARITY_EN for a trailing parity. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module iz_param_serializer
  import iz_param_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned GUARD_BITS   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  iz_param_if.slave bus
);

  localparam logic [5:0] LAST_FRAME_BIT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] LAST_GUARD_BIT = 6'(GUARD_BITS - 1);

  state_t             state_q;
  logic [PARAM_W-1:0] shreg_q;
  logic [5:0]         bit_cnt_q;
  logic               param_ready_q;
  logic               load_mode_q;
  logic               busy_q;
  logic               done_q;
`ifdef IZ_PARAM_PARITY_EN
  logic               parity_q;
`endif

  logic handshake;
  logic bit_end;
  logic timer_clr;

  assign handshake = bus.param_valid && param_ready_q;
  assign timer_clr = handshake || ((state_q == SHIFT) && bus.abort);

  iz_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (busy_q),
    .clr_i     (timer_clr),
    .bit_end_o (bit_end)
  );

  // The shift register is zeroed whenever the frame ends, so its MSB
  // doubles as the registered serial_data output.
  assign bus.param_ready = param_ready_q;
  assign bus.load_mode   = load_mode_q;
  assign bus.serial_data = shreg_q[A_MSB];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      param_ready_q <= 1'b0;
      load_mode_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef IZ_PARAM_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          param_ready_q <= 1'b1;
          if (handshake) begin
            state_q       <= SHIFT;
            shreg_q       <= bus.param_word;
            bit_cnt_q     <= '0;
            param_ready_q <= 1'b0;
            load_mode_q   <= 1'b1;
            busy_q        <= 1'b1;
`ifdef IZ_PARAM_PARITY_EN
            parity_q      <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (bus.abort || (bit_end && (bit_cnt_q == LAST_FRAME_BIT))) begin
            state_q     <= GUARD;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            load_mode_q <= 1'b0;
            done_q      <= !bus.abort;
          end else if (bit_end) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
`ifdef IZ_PARAM_PARITY_EN
            parity_q  <= parity_q ^ shreg_q[A_MSB];
            // After d[0] the completed even parity is loaded into the MSB.
            if (bit_cnt_q == 6'(PARAM_W - 1)) begin
              shreg_q <= {parity_q ^ shreg_q[A_MSB], {(PARAM_W-1){1'b0}}};
            end else begin
              shreg_q <= shreg_q << 1;
            end
`else
            shreg_q   <= shreg_q << 1;
`endif
          end
        end

        GUARD: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_GUARD_BIT) begin
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              param_ready_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iz_param_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iz_param_serializer : two instances (CLKS_PER_BIT 1 and 4) checked    |
// | against a timeline model; honours IZ_PARAM_PARITY_EN. Rev 1.0            |
// +--------------------------------------------------------------------------+
module tb_iz_param_serializer;

  localparam int G = 2;
`ifdef IZ_PARAM_PARITY_EN
  localparam int F = 33;
`else
  localparam int F = 32;
`endif
  localparam int PB = F - 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iz_param_if if1 ();
  iz_param_if if4 ();

  iz_param_serializer #(.CLKS_PER_BIT(1), .GUARD_BITS(G)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  iz_param_serializer #(.CLKS_PER_BIT(4), .GUARD_BITS(G)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- timeline model (edge n -> outputs after edge n) -------
  int          n = 0;
  bit          m_act[2], m_ab[2];
  int          m_T[2], m_L[2];
  logic [31:0] m_w[2];
  bit          m_rdy[2], m_ld[2], m_sd[2], m_bsy[2], m_dn[2];

  function automatic bit frame_bit(input logic [31:0] w, input int k);
    if (k < 32) return w[31-k];
    return ^w;
  endfunction

  task automatic model_reset(input int d);
    m_act[d] = 0; m_ab[d] = 0; m_L[d] = -1;
    m_rdy[d] = 0; m_ld[d] = 0; m_sd[d] = 0; m_bsy[d] = 0; m_dn[d] = 0;
  endtask

  task automatic model_edge(input int d, input int c, input bit v, input bit ab, input logic [31:0] w);
    bit prev_rdy;
    prev_rdy = m_rdy[d];
    if (m_act[d] && m_L[d] < 0 && ab) begin
      m_L[d] = n; m_ab[d] = 1;
    end
    if (m_act[d] && m_L[d] < 0 && n == m_T[d] + F*c) m_L[d] = n;
    if (m_act[d] && m_L[d] >= 0 && n >= m_L[d] + G*c) m_act[d] = 0;
    if (!m_act[d] && prev_rdy && v) begin
      m_act[d] = 1; m_T[d] = n; m_L[d] = -1; m_ab[d] = 0; m_w[d] = w;
    end
    if (m_act[d]) begin
      m_ld[d]  = (m_L[d] < 0);
      m_sd[d]  = m_ld[d] ? frame_bit(m_w[d], (n - m_T[d]) / c) : 1'b0;
      m_dn[d]  = (m_L[d] == n) && !m_ab[d];
      m_bsy[d] = 1; m_rdy[d] = 0;
    end else begin
      m_ld[d] = 0; m_sd[d] = 0; m_dn[d] = 0; m_bsy[d] = 0; m_rdy[d] = 1;
    end
  endtask

  initial begin
    model_reset(0); model_reset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset(0); model_reset(1);
      end else begin
        n++;
        model_edge(0, 1, if1.param_valid, if1.abort, if1.param_word);
        model_edge(1, 4, if4.param_valid, if4.abort, if4.param_word);
      end
    end
  end

  // ---------------- per-cycle compare + frame monitor ---------------------
  logic [4:0]   obs[2], prev_obs[2];
  logic [255:0] cap[2], bits_last[2], bits_prev[2];
  int           run[2], len_last[2], len_prev[2], low_run[2], last_low[2], gap[2], done_cnt[2];
  string        names[2] = '{"u1 rdy/ld/sd/bsy/dn", "u4 rdy/ld/sd/bsy/dn"};

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_obs[d] = '0; cap[d] = '0; bits_last[d] = '0; bits_prev[d] = '0;
      run[d] = 0; len_last[d] = 0; len_prev[d] = 0; low_run[d] = 0;
      last_low[d] = 0; gap[d] = 0; done_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      obs[0] = {if1.param_ready, if1.load_mode, if1.serial_data, if1.busy, if1.done};
      obs[1] = {if4.param_ready, if4.load_mode, if4.serial_data, if4.busy, if4.done};
      for (int d = 0; d < 2; d++) begin
        chk(names[d], 64'(obs[d]), 64'({m_rdy[d], m_ld[d], m_sd[d], m_bsy[d], m_dn[d]}));
        if (obs[d][0]) done_cnt[d]++;
        if (obs[d][3]) begin
          if (!prev_obs[d][3]) begin
            last_low[d] = low_run[d]; cap[d] = '0; run[d] = 0;
          end
          cap[d] = {cap[d][254:0], obs[d][2]};
          run[d]++;
          low_run[d] = 0;
        end else begin
          if (prev_obs[d][3]) begin
            bits_prev[d] = bits_last[d]; len_prev[d] = len_last[d];
            bits_last[d] = cap[d];       len_last[d] = run[d];
          end
          if (obs[d][4] && !prev_obs[d][4]) gap[d] = low_run[d];
          low_run[d]++;
        end
        prev_obs[d] = obs[d];
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic drive(input int d, input bit v, input logic [31:0] w, input bit ab);
    if (d == 0) begin
      if1.param_valid = v; if1.param_word = w; if1.abort = ab;
    end else begin
      if4.param_valid = v; if4.param_word = w; if4.abort = ab;
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? if1.param_ready : if4.param_ready;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? if1.busy : if4.busy;
  endfunction

  task automatic wait_ready(input int d);
    int k = 0;
    while (rdy_of(d) !== 1'b1 && k < 1000) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 1000) begin
      tests++; fails++;
      $display("FAIL ready timeout on dut %0d: got busy, expected ready", d);
    end
  endtask

  // Returns just after the handshake edge; the word is then scrambled.
  task automatic send(input int d, input logic [31:0] w, input bit ab);
    @(negedge clk); #1;
    drive(d, 1'b1, w, ab);
    wait_ready(d);
    @(posedge clk); #1;
    drive(d, 1'b0, ~w, 1'b0);
  endtask

  task automatic wait_idle(input int d);
    int k = 0;
    @(negedge clk);
    while ((busy_of(d) !== 1'b0 || rdy_of(d) !== 1'b1) && k < 1000) begin
      @(negedge clk); k++;
    end
    if (k >= 1000) begin
      tests++; fails++;
      $display("FAIL idle timeout on dut %0d: got busy, expected idle", d);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_stream(input logic [31:0] w);
`ifdef IZ_PARAM_PARITY_EN
    return {31'b0, w, ^w};
`else
    return {32'b0, w};
`endif
  endfunction

  // ---------------- directed tests ----------------------------------------
  int d0;
  logic [32:0] basic_pat;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(1, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Reset held with param_valid high
    repeat (3) @(negedge clk);
    chk("reset outputs u1", 64'({if1.param_ready, if1.load_mode, if1.serial_data, if1.busy, if1.done}), 64'd0);
    chk("reset outputs u4", 64'({if4.param_ready, if4.load_mode, if4.serial_data, if4.busy, if4.done}), 64'd0);
    #1;
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-reset ready/load u1", 64'({if1.param_ready, if1.load_mode}), 64'b10);

    // Basic frame, CLKS_PER_BIT=1
    d0 = done_cnt[0];
    send(0, 32'hA5C3_0F81, 1'b0);
    wait_idle(0);
    basic_pat = (F == 33) ? {32'b1010_0101_1100_0011_0000_1111_1000_0001, 1'b0}
                          : {1'b0, 32'b1010_0101_1100_0011_0000_1111_1000_0001};
    chk("basic load_mode length", 64'(len_last[0]), 64'(F));
    chk("basic serial stream", bits_last[0][63:0], 64'(basic_pat));
    chk("basic done pulses", 64'(done_cnt[0] - d0), 64'd1);
    chk("basic low cycles before ready", 64'(gap[0]), 64'd2);

    // abort while idle must do nothing
    @(negedge clk); #1; drive(0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk); #1; drive(0, 1'b0, 32'h0, 1'b0);
    chk("idle abort ignored", 64'({if1.param_ready, if1.busy}), 64'b10);

    // Slow timing, handshake with abort also high (handshake wins)
    send(1, 32'h8000_0001, 1'b1);
    wait_idle(1);
    chk("slow load_mode length", 64'(len_last[1]), 64'(F*4));
    chk("slow first 4 cycles", 64'(bits_last[1][len_last[1]-1 -: 4]), 64'hF);
    chk("slow last data 4 cycles", 64'(bits_last[1][PB*4 +: 4]), 64'hF);
    chk("slow high cycle count", 64'($countones(bits_last[1])), 64'd8);
    chk("slow low cycles before ready", 64'(gap[1]), 64'd8);

    // Abort at bit 10 of all-ones; abort held into GUARD is ignored
    d0 = done_cnt[0];
    send(0, 32'hFFFF_FFFF, 1'b0);
    repeat (11) @(negedge clk);
    #1; drive(0, 1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    #1; drive(0, 1'b0, 32'h0, 1'b0);
    wait_idle(0);
    chk("abort load_mode length", 64'(len_last[0]), 64'd11);
    chk("abort bits sent", 64'(bits_last[0][10:0]), 64'h7FF);
    chk("abort no done", 64'(done_cnt[0] - d0), 64'd0);
    chk("abort low cycles before ready", 64'(gap[0]), 64'd2);

    // Abort mid-bit on the slow instance
    send(1, 32'h1234_5678, 1'b0);
    repeat (7) @(negedge clk);
    #1; drive(1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #1; drive(1, 1'b0, 32'h0, 1'b0);
    wait_idle(1);
    chk("slow abort length", 64'(len_last[1]), 64'd7);
    chk("slow abort low cycles before ready", 64'(gap[1]), 64'd8);

    // Back-to-back with param_valid held high
    @(negedge clk); #1;
    drive(0, 1'b1, 32'h3C3C_0FF0, 1'b0);
    wait_ready(0);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h5A5A_1234, 1'b0);
    @(negedge clk); #1;
    wait_ready(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0000_0000, 1'b0);
    wait_idle(0);
    chk("b2b frame1 stream", bits_prev[0][63:0], exp_stream(32'h3C3C_0FF0));
    chk("b2b frame2 stream", bits_last[0][63:0], exp_stream(32'h5A5A_1234));
    chk("b2b frame2 length", 64'(len_last[0]), 64'(F));
    chk("b2b low gap between frames", 64'(last_low[0]), 64'd3);

    // Async reset mid-frame
    send(0, 32'hF0F0_F0F0, 1'b0);
    repeat (5) @(negedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({if1.param_ready, if1.load_mode, if1.serial_data, if1.busy, if1.done}), 64'd0);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no resume after reset", 64'({if1.param_ready, if1.load_mode, if1.busy}), 64'b100);

    // Final-bit boundary (parity bit when enabled, else d[0])
    send(0, 32'h0000_0007, 1'b0);
    wait_idle(0);
    chk("word 7 length", 64'(len_last[0]), 64'(F));
    chk("word 7 final bit", 64'(bits_last[0][0]), 64'd1);
    send(0, 32'h0000_0003, 1'b0);
    wait_idle(0);
    chk("word 3 final bit", 64'(bits_last[0][0]), (F == 33) ? 64'd0 : 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/iz_param_serializer.md
# iz_param_serializer

Transmit-side driver for the neuron core's serial parameter-load port. Accepts one 32-bit parameter word {a,b,c,d} (8 bits each) over a valid/ready handshake. Frames it as load_mode high while serial_data carries the word MSB-first, one bit per bit period. It sits in the host-side test harness or a companion controller tile, and its load_mode/serial_data outputs drive the neuron tile's uio_in[0]/uio_in[1].

## Interface
- CLKS_PER_BIT, default 1: clock cycles each bit is held; legal range 1..255.
- GUARD_BITS, default 2: bit periods with load_mode low after each frame; legal range 1..15.
- clk  input  1  single system clock; all logic is rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- param_word  input  32  {a[31:24], b[23:16], c[15:8], d[7:0]}; sampled only on handshake.
- param_valid  input  1  word offered.
- param_ready  output  1  high only in IDLE; reset value 0 during reset, 1 after.
- abort  input  1  synchronous frame cancel.
- load_mode  output  1  frame envelope; reset 0.
- serial_data  output  1  data bit; reset 0; forced 0 whenever load_mode=0.
- busy  output  1  high in SHIFT and GUARD; reset 0.
- done  output  1  one-cycle pulse on normal frame completion; reset 0.

## Operation
- States: IDLE, SHIFT, GUARD. Reset enters IDLE.
- IDLE: param_ready=1. On param_valid&&param_ready, latch param_word into the shift register, clear bit_cnt and tick counter, and go to SHIFT.
- SHIFT: load_mode=1, serial_data=shreg[31]. At the end of each bit period, shift left and increment bit_cnt. After the last frame bit, go to GUARD and pulse done.
- GUARD: load_mode=0, serial_data=0. Stay for GUARD_BITS bit periods, then go to IDLE.
- abort in SHIFT: go to GUARD next cycle. load_mode drops on that edge and done is not pulsed. abort in IDLE or GUARD is ignored.
- abort and param_valid together in IDLE: handshake wins; abort is ignored.
- param_word changes after the handshake do not affect the frame in flight.
- Async reset mid-frame: all outputs go to their reset values immediately. No partial frame resumes.
- Counters: tick counter is 8 bits and wraps at CLKS_PER_BIT-1. bit_cnt is 6 bits. No arithmetic overflow is reachable.

## Timing
- Handshake at edge T: load_mode rises and serial_data=param_word[31] from T+1.
- Bit k (0 = MSB) is valid for cycles T+1+k·CLKS_PER_BIT through T+(k+1)·CLKS_PER_BIT.
- load_mode is high for exactly FRAME_BITS·CLKS_PER_BIT cycles.
- done is high in the first GUARD cycle.
- param_ready returns after GUARD_BITS·CLKS_PER_BIT low cycles.
- Minimum handshake-to-handshake spacing: (FRAME_BITS+GUARD_BITS)·CLKS_PER_BIT + 1 cycles.
- Outputs are registered; there are no combinational paths from inputs to load_mode or serial_data.

## Configuration
- IZ_PARAM_PARITY_EN defined: FRAME_BITS=33. One even-parity bit (XOR of all 32 data bits) follows d[0], with load_mode still high.
- IZ_PARAM_PARITY_EN undefined: FRAME_BITS=32. No parity logic is synthesized.

## Structure
- Package iz_param_pkg holds:
  - PARAM_W=32
  - field offsets A_MSB/B_MSB/C_MSB/D_MSB
  - the FRAME_BITS function of IZ_PARAM_PARITY_EN
  - state enum {IDLE, SHIFT, GUARD}
- Sub-module iz_bit_timer: tick counter that emits a one-cycle bit_end strobe every CLKS_PER_BIT cycles while enabled; cleared on handshake and abort.
- The top level holds the FSM, shift register, bit_cnt and parity accumulator.

## Test plan
- Reset: hold rst_n=0 with param_valid=1. Required: load_mode=serial_data=busy=done=param_ready=0. After release, param_ready=1 and no frame starts until a handshake.
- Basic frame, CLKS_PER_BIT=1, word 0xA5C3_0F81. Required: serial_data sequence 1010_0101_1100_0011_0000_1111_1000_0001 over 32 cycles with load_mode high for 32 cycles. Then a done pulse, 2 low cycles, and param_ready=1.
- Slow timing, CLKS_PER_BIT=4, word 0x8000_0001. Required: serial_data high for the first 4 cycles and the last 4 cycles of a 128-cycle load_mode window.
- Abort at bit 10 of word 0xFFFF_FFFF. Required: load_mode falls on the next edge, no done pulse, then GUARD_BITS·CLKS_PER_BIT low cycles before param_ready.
- Back-to-back: param_valid held high with two words. Required: the second frame starts exactly GUARD_BITS·CLKS_PER_BIT+1 cycles after the first load_mode falls, and the second word is latched only at its own handshake.
- Parity build, word 0x0000_0007. Required: 33 load_mode cycles with final bit 1. For word 0x0000_0003 the final bit is 0.
